// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge, request error decode.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned SIZE_BYTES = 1024
) (
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged,
  output logic        err
);

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_BU:   return {24'h0, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_HU:   return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] mask;
    case (f3)
      F3_B:    mask = 32'h0000_00ff << {off, 3'b000};
      F3_H:    mask = 32'h0000_ffff << {off, 3'b000};
      default: mask = 32'hffff_ffff;
    endcase
    return (old & ~mask) | ((wd << {off, 3'b000}) & mask);
  endfunction

  logic        legal;
  logic        misalign;
  logic [32:0] size;
  logic [32:0] end_addr;

  always_comb begin
    legal = 1'b0;
    if (store) legal = funct3 inside {F3_B, F3_H, F3_W};
    else       legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};

    size = 33'd4;
    if (funct3[1:0] == 2'b00)      size = 33'd1;
    else if (funct3[1:0] == 2'b01) size = 33'd2;

    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    // 33-bit sum so addresses near 2^32 cannot wrap into range.
    end_addr = {1'b0, addr} + size;
    err      = !legal || misalign || (end_addr > 33'(SIZE_BYTES));
  end

  assign load_data = extract(rdata, addr[1:0], funct3);
  assign merged    = merge(rdata, wdata, addr[1:0], funct3);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit in front of a word-only memory port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned SIZE_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // the sender holds valid and its payload stable until then, and valid never waits on ready.
  lsu_state_t  state_q, state_d;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        in_idle;
  logic [2:0]  a_f3;
  logic [31:0] a_addr;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        a_err;

  assign in_idle = (state_q == IDLE);
  assign a_f3    = in_idle ? req_funct3 : f3_q;
  assign a_addr  = in_idle ? req_addr   : addr_q;

  lsu_align #(.SIZE_BYTES(SIZE_BYTES)) u_align (
    .store     (req_store),
    .funct3    (a_f3),
    .addr      (a_addr),
    .rdata     (mem_rdata),
    .wdata     (word_q),
    .load_data (load_data),
    .merged    (merged),
    .err       (a_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (a_err)                    state_d = RESP;
        else if (!req_store)          state_d = LOAD;
        else if (req_funct3 == F3_W)  state_d = WRITE;
        else                          state_d = RMW_RD;
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // word_q holds the store data on accept and is overwritten by the merged word for SB/SH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          word_q  <= req_wdata;
          rdata_q <= 32'h0;
          err_q   <= a_err;
        end
        LOAD:   rdata_q <= load_data;
        RMW_RD: word_q  <= merged;
        RESP: if (resp_ready) begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = in_idle;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_read   = (state_q == LOAD) || (state_q == RMW_RD);
  assign mem_write  = (state_q == WRITE);
  assign mem_addr   = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = mem_write ? word_q : 32'h0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 1 KiB word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  load_store_unit #(.SIZE_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) begin
      wr_cnt <= wr_cnt + 1;
      last_wdata <= mem_wdata;
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                     input int exp_rd, input int exp_wr);
    int lat, rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(tag, st, f3, a, wd);
    wait_resp(lat);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    finish_resp(tag);
    chk({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    chk({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat, rd0, wr0;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Preload through the unit with word stores.
    txn("sw_pre10", 1'b1, F3_W, 32'h10, 32'h8899_AABB, 32'h0, 1'b0, 2, 0, 1);
    chk("pre10_mem", mem[4], 32'h8899_AABB);
    txn("sw_pre3fc", 1'b1, F3_W, 32'h3FC, 32'h0BAD_F00D, 32'h0, 1'b0, 2, 0, 1);

    txn("lb_11",  1'b0, F3_B,  32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0, 2, 1, 0);
    txn("lbu_11", 1'b0, F3_BU, 32'h11, 32'h0, 32'h0000_00AA, 1'b0, 2, 1, 0);
    txn("lh_12",  1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF_8899, 1'b0, 2, 1, 0);
    txn("lhu_12", 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000_8899, 1'b0, 2, 1, 0);
    txn("lb_10",  1'b0, F3_B,  32'h10, 32'h0, 32'hFFFF_FFBB, 1'b0, 2, 1, 0);
    txn("lhu_10", 1'b0, F3_HU, 32'h10, 32'h0, 32'h0000_AABB, 1'b0, 2, 1, 0);
    txn("lw_3fc", 1'b0, F3_W,  32'h3FC, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 1, 0);
    txn("lbu_3ff", 1'b0, F3_BU, 32'h3FF, 32'h0, 32'h0000_000B, 1'b0, 2, 1, 0);

    txn("sb_12", 1'b1, F3_B, 32'h12, 32'h0000_005A, 32'h0, 1'b0, 3, 1, 1);
    chk("sb_12_wdata", last_wdata, 32'h885A_AABB);
    txn("lw_10", 1'b0, F3_W, 32'h10, 32'h0, 32'h885A_AABB, 1'b0, 2, 1, 0);
    txn("sh_3fe", 1'b1, F3_H, 32'h3FE, 32'hFFFF_C0DE, 32'h0, 1'b0, 3, 1, 1);
    chk("sh_3fe_wdata", last_wdata, 32'hC0DE_F00D);

    txn("err_lw_11",   1'b0, F3_W,   32'h11,  32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("err_sh_13",   1'b1, F3_H,   32'h13,  32'h1234, 32'h0, 1'b1, 1, 0, 0);
    txn("err_lw_3fe",  1'b0, F3_W,   32'h3FE, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("err_lw_400",  1'b0, F3_W,   32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("err_lb_400",  1'b0, F3_B,   32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("err_ld_f011", 1'b0, 3'b011, 32'h10,  32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("err_st_f100", 1'b1, F3_BU,  32'h10,  32'h55, 32'h0, 1'b1, 1, 0, 0);
    chk("err_mem_kept", mem[4], 32'h885A_AABB);

    // Response back-pressure with a competing request presented meanwhile.
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue("sw_stall", 1'b1, F3_W, 32'h20, 32'hDEAD_BEEF);
    wait_resp(lat);
    chk("sw_stall_latency", 32'(lat), 32'd2);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      chk("stall_resp_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, 32'h0);
      chk("stall_err", 32'(resp_err), 32'd0);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_addr = 32'h0; req_funct3 = 3'b000;
    finish_resp("sw_stall");
    repeat (2) @(posedge clk);
    #1;
    chk("stall_no_accept_state", 32'(dbg_state), 32'(IDLE));
    chk("stall_reads", 32'(rd_cnt - rd0), 32'd0);
    chk("stall_writes", 32'(wr_cnt - wr0), 32'd1);
    chk("stall_mem20", mem[8], 32'hDEAD_BEEF);

    // Reset during the read half of a read-modify-write.
    wr0 = wr_cnt;
    issue("sh_rst", 1'b1, F3_H, 32'h10, 32'h0000_1234);
    chk("sh_rst_in_rmw", 32'(dbg_state), 32'(RMW_RD));
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_writes", 32'(wr_cnt - wr0), 32'd0);
    chk("rst_mid_mem10", mem[4], 32'h885A_AABB);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("rst_after");
    chk("rst_after_writes", 32'(wr_cnt - wr0), 32'd0);

    txn("lw_after_rst", 1'b0, F3_W, 32'h10, 32'h0, 32'h885A_AABB, 1'b0, 2, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
